// File: rtl/req_arbiter3.sv
// Three-way fixed-priority request arbiter (a > b > c). Grants are not preemptive and are
// limited to HOLD_MAX cycles; a requester cut off by timeout is skipped once if others wait.
module req_arbiter3 #(
    parameter int unsigned HOLD_MAX = 15  // legal range 2..255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_a_i,
    input  logic       req_b_i,
    input  logic       req_c_i,
    input  logic       done_i,
    output logic       gnt_a_o,
    output logic       gnt_b_o,
    output logic       gnt_c_o,
    output logic [1:0] grant_code_o,
    output logic       busy_o,
    output logic       timeout_o
);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } state_e;

    localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

    state_e     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;    // one-hot {a, b, c}
    logic [2:0] mask_q, mask_d;  // requester excluded from the next contested arbitration
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;

    logic [2:0] req;
    logic [2:0] req_unmasked;
    logic [2:0] req_eff;
    logic [2:0] winner;
    logic       grantee_req;

    assign req          = {req_a_i, req_b_i, req_c_i};
    assign req_unmasked = req & ~mask_q;
    // The mask only bites when someone else is asking; a lone masked requester still wins.
    assign req_eff      = (req_unmasked != 3'b000) ? req_unmasked : req;
    assign grantee_req  = |(req & gnt_q);

    always_comb begin
        winner = 3'b000;
        if (req_eff[2]) begin
            winner = 3'b100;
        end else if (req_eff[1]) begin
            winner = 3'b010;
        end else if (req_eff[0]) begin
            winner = 3'b001;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        mask_d     = mask_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req != 3'b000) begin
                    state_d    = StGrant;
                    gnt_d      = winner;
                    mask_d     = 3'b000;
                    hold_cnt_d = 8'd0;
                end
            end
            StGrant: begin
                // A normal release takes precedence over a coincident timeout.
                if (done_i || !grantee_req) begin
                    state_d    = StRelease;
                    gnt_d      = 3'b000;
                    hold_cnt_d = 8'd0;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d    = StRelease;
                    gnt_d      = 3'b000;
                    mask_d     = gnt_q;
                    hold_cnt_d = 8'd0;
                    timeout_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d    = StIdle;
                gnt_d      = 3'b000;
                hold_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            gnt_q      <= 3'b000;
            mask_q     <= 3'b000;
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            mask_q     <= mask_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Code is decoded from the grant flops so the two can never disagree.
    always_comb begin
        grant_code_o = 2'b00;
        unique case (gnt_q)
            3'b100:  grant_code_o = 2'b11;
            3'b010:  grant_code_o = 2'b10;
            3'b001:  grant_code_o = 2'b01;
            default: grant_code_o = 2'b00;
        endcase
    end

    assign gnt_a_o   = gnt_q[2];
    assign gnt_b_o   = gnt_q[1];
    assign gnt_c_o   = gnt_q[0];
    assign busy_o    = (state_q == StGrant);
    // Registered pulse, high during the release cycle that follows a forced end.
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_req_arbiter3.sv
// Self-checking bench for req_arbiter3: directed scenarios plus random traffic, each cycle
// compared against a requester-level reference model.
module tb_req_arbiter3;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic       req_a, req_b, req_c, done;
    logic       gnt_a, gnt_b, gnt_c;
    logic [1:0] grant_code;
    logic       busy, timeout;
    logic [6:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner 0 none, 1 a, 2 b, 3 c; held counts granted cycles so far.
    int m_owner, m_held, m_mask;
    bit m_rel, m_to;

    req_arbiter3 #(.HOLD_MAX(HOLD)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_c_i     (req_c),
        .done_i      (done),
        .gnt_a_o     (gnt_a),
        .gnt_b_o     (gnt_b),
        .gnt_c_o     (gnt_c),
        .grant_code_o(grant_code),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    assign obs = {gnt_a, gnt_b, gnt_c, grant_code, busy, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = 0;
        m_held  = 0;
        m_mask  = 0;
        m_rel   = 0;
        m_to    = 0;
    endtask

    task automatic model_step();
        logic [3:1] r;
        int         win;
        r   = {req_c, req_b, req_a};
        win = 0;
        if (m_rel) begin
            m_rel = 0;
            m_to  = 0;
        end else if (m_owner == 0) begin
            for (int i = 1; i <= 3; i++) if (r[i] && i != m_mask && win == 0) win = i;
            for (int i = 1; i <= 3; i++) if (r[i] && win == 0) win = i;
            if (win != 0) begin
                m_owner = win;
                m_held  = 1;
                m_mask  = 0;
            end
        end else if (done || !r[m_owner]) begin
            m_owner = 0;
            m_rel   = 1;
        end else if (m_held == HOLD) begin
            m_mask  = m_owner;
            m_owner = 0;
            m_rel   = 1;
            m_to    = 1;
        end else begin
            m_held++;
        end
    endtask

    function automatic logic [6:0] exp_vec();
        logic [1:0] code;
        case (m_owner)
            1:       code = 2'b11;
            2:       code = 2'b10;
            3:       code = 2'b01;
            default: code = 2'b00;
        endcase
        return {m_owner == 1, m_owner == 2, m_owner == 3, code, m_owner != 0, m_to};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic set_in(input logic a, input logic b, input logic c, input logic d);
        req_a = a;
        req_b = b;
        req_c = c;
        done  = d;
    endtask

    task automatic settle();
        set_in(0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0);
        model_reset();
        #3;
        n_checks++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_pre_clock: got %b expected %b", obs, 7'b0);
        end
        repeat (2) begin
            tick();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_held: got %b expected %b", obs, exp_vec());
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_c();
        set_in(0, 0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            if (k == 4) set_in(0, 0, 1, 1);
            if (k == 5) set_in(0, 0, 0, 0);
            tick();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_c step %0d: got %b expected %b", k, obs, exp_vec());
            end
            if (k == 1) begin
                n_checks++;
                if (grant_code !== 2'b01 || gnt_c !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_c_grant: got code %b gnt_c %b expected 01 1",
                             grant_code, gnt_c);
                end
            end
            if (k == 4) begin
                n_checks++;
                if (busy !== 1'b0 || grant_code !== 2'b00) begin
                    n_fail++;
                    $display("FAIL single_c_release: got busy %b code %b expected 0 00",
                             busy, grant_code);
                end
            end
        end
        settle();
    endtask

    task automatic test_all_three();
        set_in(1, 1, 1, 0);
        tick();
        n_checks++;
        if (grant_code !== 2'b11 || gnt_a !== 1'b1) begin
            n_fail++;
            $display("FAIL all_three_first: got code %b gnt_a %b expected 11 1", grant_code, gnt_a);
        end
        set_in(1, 1, 1, 1);
        tick();
        set_in(0, 1, 1, 0);
        tick();
        tick();
        n_checks++;
        if (grant_code !== 2'b10 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL all_three_second: got %b expected code 10 vec %b", obs, exp_vec());
        end
        settle();
    endtask

    task automatic test_timeout_mask();
        set_in(0, 1, 1, 0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL timeout_mask step %0d: got %b expected %b", k, obs, exp_vec());
            end
            if (k <= HOLD) begin
                n_checks++;
                if (grant_code !== 2'b10 || timeout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_hold %0d: got code %b to %b expected 10 0",
                             k, grant_code, timeout);
                end
            end
            if (k == HOLD + 1) begin
                n_checks++;
                if (timeout !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_pulse: got to %b busy %b expected 1 0", timeout, busy);
                end
            end
            if (k == 7) begin
                n_checks++;
                if (grant_code !== 2'b01) begin
                    n_fail++;
                    $display("FAIL timeout_masked_next: got %b expected 01", grant_code);
                end
            end
        end
        settle();
    endtask

    task automatic test_no_preempt();
        set_in(0, 0, 1, 0);
        tick();
        set_in(1, 0, 1, 0);
        repeat (2) begin
            tick();
            n_checks++;
            if (grant_code !== 2'b01 || gnt_a !== 1'b0) begin
                n_fail++;
                $display("FAIL no_preempt_hold: got code %b gnt_a %b expected 01 0",
                         grant_code, gnt_a);
            end
        end
        set_in(1, 0, 1, 1);
        tick();
        set_in(1, 0, 0, 0);
        tick();
        tick();
        n_checks++;
        if (grant_code !== 2'b11 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL no_preempt_after: got %b expected code 11 vec %b", obs, exp_vec());
        end
        settle();
    endtask

    task automatic test_done_at_limit();
        set_in(0, 1, 1, 0);
        repeat (HOLD) tick();
        set_in(0, 1, 1, 1);
        tick();
        n_checks++;
        if (timeout !== 1'b0 || busy !== 1'b0 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL done_at_limit_release: got %b expected to 0 vec %b", obs, exp_vec());
        end
        set_in(0, 1, 1, 0);
        tick();
        tick();
        n_checks++;
        if (grant_code !== 2'b10) begin
            n_fail++;
            $display("FAIL done_at_limit_nomask: got %b expected 10", grant_code);
        end
        settle();
    endtask

    task automatic test_async_reset();
        set_in(1, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset_drop: got %b expected %b", obs, 7'b0);
        end
        tick();
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_reset_held: got %b expected %b", obs, exp_vec());
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (grant_code !== 2'b11 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_reset_regrant: got %b expected code 11 vec %b", obs, exp_vec());
        end
        settle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 1) == 0, $urandom_range(0, 4) == 0);
            tick();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %b expected %b", k, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_c();
        test_all_three();
        test_timeout_mask();
        test_no_preempt();
        test_done_at_limit();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
